// File: rtl/utf8_pkg.sv
// Shared types and byte-classification helpers for the UTF-8 stream decoder.
package utf8_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONT   = 2'd1,
    ST_REPLAY = 2'd2
  } dec_state_e;

  localparam logic [20:0] UTF8_REPLACEMENT_CP = 21'h0FFFD;

  typedef struct packed {
    logic [20:0] cp;
    logic        err;
    logic [2:0]  len;
  } fifo_entry_t;

  // Returns {invalid, need}: need is the number of continuation bytes expected.
  function automatic logic [2:0] lead_class(input logic [7:0] b);
    logic [2:0] r;
    if (b <= 8'h7F)                     r = 3'b000;
    else if (b >= 8'hC2 && b <= 8'hDF)  r = 3'b001;
    else if (b >= 8'hE0 && b <= 8'hEF)  r = 3'b010;
    else if (b >= 8'hF0 && b <= 8'hF4)  r = 3'b011;
    else                                r = 3'b100;
    return r;
  endfunction

  // Returns {lo, hi} bounds for the first continuation after a given lead byte.
  function automatic logic [15:0] first_cont_range(input logic [7:0] lead);
    logic [15:0] r;
    case (lead)
      8'hE0:   r = {8'hA0, 8'hBF};
      8'hED:   r = {8'h80, 8'h9F};
      8'hF0:   r = {8'h90, 8'hBF};
      8'hF4:   r = {8'h80, 8'h8F};
      default: r = {8'h80, 8'hBF};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/utf8_out_fifo.sv
// Two-entry output FIFO for decoded tokens; a full FIFO accepts a push when it is popped in the same cycle.
module utf8_out_fifo import utf8_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  fifo_entry_t wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output fifo_entry_t rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [1:0]  count
);

  fifo_entry_t mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic        do_wr;
  logic        do_rd;

  assign rd_valid = (count != 2'd0);
  assign wr_ready = (count != 2'd2) || rd_ready;
  assign do_wr    = wr_valid && wr_ready;
  assign do_rd    = rd_valid && rd_ready;
  // Head reads as zero when empty so the visible outputs are clean after reset.
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= ~wr_ptr;
      if (do_rd) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_wr} - {1'b0, do_rd};
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/utf8_stream_decoder.sv
// Byte-serial UTF-8 decoder with maximal-subpart error tokens and a 2-entry output FIFO.
// Optional feature: define UTF8_DEC_ERRCNT_EN to build the saturating error counter.
module utf8_stream_decoder import utf8_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  output logic [20:0] out_cp,
  output logic        out_err,
  output logic [2:0]  out_len,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic [7:0]  err_count
);

  dec_state_e  state, state_nx;
  logic [1:0]  need, need_nx;
  logic [1:0]  got, got_nx;
  logic [20:0] acc, acc_nx;
  logic [7:0]  lead, lead_nx;
  logic [7:0]  hold, hold_nx;
  logic        flush_pend;
  logic        pend_eff;
  logic        flush_go;
  logic        take;
  logic        can_push;
  logic        push;
  fifo_entry_t push_data;
  fifo_entry_t head;
  logic [1:0]  fifo_count;
  logic [7:0]  cls_byte;
  logic [2:0]  cls;
  logic [15:0] rng;
  logic        cont_ok;

  // A flush pulse blocks input in the cycle it arrives, before it is registered.
  assign pend_eff = flush_pend || flush;
  assign in_ready = !rst && (state != ST_REPLAY) && !pend_eff && (fifo_count != 2'd2);
  assign take     = in_valid && in_ready;
  assign flush_go = pend_eff && can_push;

  assign cls_byte = (state == ST_REPLAY) ? hold : in_byte;
  assign cls      = lead_class(cls_byte);
  assign rng      = first_cont_range(lead);
  assign cont_ok  = (got == 2'd1) ? (in_byte >= rng[15:8] && in_byte <= rng[7:0])
                                  : (in_byte[7:6] == 2'b10);

  always_comb begin
    state_nx  = state;
    need_nx   = need;
    got_nx    = got;
    acc_nx    = acc;
    lead_nx   = lead;
    hold_nx   = hold;
    push      = 1'b0;
    push_data = '0;
    if (flush_go && state == ST_CONT) begin
      push           = 1'b1;
      push_data.cp   = UTF8_REPLACEMENT_CP;
      push_data.err  = 1'b1;
      push_data.len  = {1'b0, got};
      state_nx       = ST_IDLE;
    end else begin
      case (state)
        ST_CONT: begin
          if (take) begin
            if (cont_ok) begin
              acc_nx  = {acc[14:0], in_byte[5:0]};
              got_nx  = got + 2'd1;
              need_nx = need - 2'd1;
              if (need == 2'd1) begin
                push          = 1'b1;
                push_data.cp  = acc_nx;
                push_data.len = {1'b0, got} + 3'd1;
                state_nx      = ST_IDLE;
              end
            end else begin
              // Offending byte is kept and re-classified as a fresh lead next cycle.
              push          = 1'b1;
              push_data.cp  = UTF8_REPLACEMENT_CP;
              push_data.err = 1'b1;
              push_data.len = {1'b0, got};
              hold_nx       = in_byte;
              state_nx      = ST_REPLAY;
            end
          end
        end
        default: begin
          if ((state == ST_IDLE && take) || (state == ST_REPLAY && can_push)) begin
            state_nx = ST_IDLE;
            if (cls[2]) begin
              push          = 1'b1;
              push_data.cp  = UTF8_REPLACEMENT_CP;
              push_data.err = 1'b1;
              push_data.len = 3'd1;
            end else if (cls[1:0] == 2'd0) begin
              push          = 1'b1;
              push_data.cp  = {14'd0, cls_byte[6:0]};
              push_data.len = 3'd1;
            end else begin
              state_nx = ST_CONT;
              need_nx  = cls[1:0];
              got_nx   = 2'd1;
              lead_nx  = cls_byte;
              acc_nx   = (cls[1:0] == 2'd1) ? {16'd0, cls_byte[4:0]} :
                         (cls[1:0] == 2'd2) ? {17'd0, cls_byte[3:0]} :
                                              {18'd0, cls_byte[2:0]};
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      flush_pend <= 1'b0;
    end else begin
      state      <= state_nx;
      flush_pend <= pend_eff && !flush_go;
    end
  end

  always_ff @(posedge clk) begin
    need <= need_nx;
    got  <= got_nx;
    acc  <= acc_nx;
    lead <= lead_nx;
    hold <= hold_nx;
  end

  utf8_out_fifo u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (push_data),
    .wr_valid (push),
    .wr_ready (can_push),
    .rd_data  (head),
    .rd_valid (out_valid),
    .rd_ready (out_ready),
    .count    (fifo_count)
  );

  assign out_cp  = head.cp;
  assign out_err = head.err;
  assign out_len = head.len;
  assign busy    = (state == ST_CONT);

`ifdef UTF8_DEC_ERRCNT_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [7:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= 8'd0;
    end else if (push && push_data.err) begin
      err_cnt_q <= sat_inc8(err_cnt_q);
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 8'd0;
`endif

endmodule
